// File: rtl/wb_slave_resp.sv
// WISHBONE slave with a byte-addressable word memory and programmable wait states,
// retries and out-of-window errors; supports incrementing read/write bursts.
module wb_slave_resp #(
    parameter int AW             = 32,
    parameter int MEM_WORDS_LOG2 = 8
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic          WE_I,
    input  logic [AW-1:0] ADR_I,
    input  logic [3:0]    SEL_I,
    input  logic [31:0]   DAT_I,
    input  logic [2:0]    CTI_I,
    output logic [31:0]   DAT_O,
    output logic          ACK_O,
    output logic          ERR_O,
    output logic          RTY_O,
    input  logic [3:0]    cfg_wait_i,
    input  logic [3:0]    cfg_rty_i,
    input  logic          cfg_err_en_i,
    output logic [15:0]   xfer_cnt_o
);
    localparam int MW    = MEM_WORDS_LOG2;
    localparam int DEPTH = 1 << MW;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {K_ACK, K_ERR, K_RTY} kind_t;

    state_t        state_reg, state_next;
    kind_t         kind_reg, kind_next, new_kind, raise_kind;
    logic [3:0]    wait_reg, wait_next;
    logic          ack_reg, ack_next;
    logic          err_reg, err_next;
    logic          rty_reg, rty_next;
    logic [31:0]   dat_reg;
    logic [15:0]   xfer_cnt_reg;
    logic [3:0]    rty_cnt_reg;
    logic          ack_done_reg;
    logic          rst_load_reg;
    logic          raise;
    logic          rd_load;
    logic [MW-1:0] rd_addr;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte [4];
    logic          mem_we;
    logic [MW-1:0] word_addr;
    logic          out_of_window;

    assign word_addr     = ADR_I[MW+1:2];
    assign out_of_window = |ADR_I[AW-1:MW+2];
    wire   unused_adr_bits = &{1'b0, ADR_I[1:0]};

    // A beat commits only while the master still owns the bus.
    assign mem_we = ack_reg && CYC_I && STB_I && WE_I;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_b [DEPTH];

            always_ff @(posedge CLK_I) begin
                if (mem_we && SEL_I[gi]) begin
                    mem_b[word_addr] <= DAT_I[gi*8 +: 8];
                end
            end

            assign rd_byte[gi] = mem_b[rd_addr];
        end
    endgenerate

    assign rd_word = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

    always_comb begin
        if (rty_cnt_reg != 4'd0) begin
            new_kind = K_RTY;
        end else if (out_of_window && cfg_err_en_i) begin
            new_kind = K_ERR;
        end else begin
            new_kind = K_ACK;
        end
    end

    always_comb begin
        state_next = state_reg;
        kind_next  = kind_reg;
        wait_next  = wait_reg;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        rty_next   = 1'b0;
        rd_load    = 1'b0;
        rd_addr    = word_addr;
        raise      = 1'b0;
        raise_kind = kind_reg;
        case (state_reg)
            IDLE: begin
                if (CYC_I && STB_I) begin
                    kind_next = new_kind;
                    if (cfg_wait_i == 4'd0) begin
                        raise      = 1'b1;
                        raise_kind = new_kind;
                    end else begin
                        state_next = WAIT;
                        wait_next  = cfg_wait_i - 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!CYC_I) begin
                    state_next = IDLE;
                end else if (wait_reg == 4'd0) begin
                    raise = 1'b1;
                end else begin
                    wait_next = wait_reg - 4'd1;
                end
            end
            RESP: begin
                // Burst beats prefetch the next word so ACK can stay high back to back.
                if (CYC_I && ack_reg && STB_I && CTI_I == 3'b010) begin
                    ack_next = 1'b1;
                    rd_load  = !WE_I;
                    rd_addr  = word_addr + MW'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (raise) begin
            state_next = RESP;
            ack_next   = (raise_kind == K_ACK);
            err_next   = (raise_kind == K_ERR);
            rty_next   = (raise_kind == K_RTY);
            rd_load    = (raise_kind == K_ACK) && !WE_I;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_reg    <= IDLE;
            kind_reg     <= K_ACK;
            wait_reg     <= 4'd0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            rty_reg      <= 1'b0;
            dat_reg      <= 32'd0;
            xfer_cnt_reg <= 16'd0;
            rty_cnt_reg  <= 4'd0;
            ack_done_reg <= 1'b0;
            rst_load_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            kind_reg     <= kind_next;
            wait_reg     <= wait_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            rty_reg      <= rty_next;
            dat_reg      <= rd_load ? rd_word : 32'd0;
            rst_load_reg <= 1'b0;
            if (ack_reg && STB_I) begin
                xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
            end
            // Retry budget refills after reset and once an ACKed cycle is closed.
            if (rst_load_reg || (ack_done_reg && !CYC_I)) begin
                rty_cnt_reg <= cfg_rty_i;
            end else if (rty_next && rty_cnt_reg != 4'd0) begin
                rty_cnt_reg <= rty_cnt_reg - 4'd1;
            end
            if (ack_reg && STB_I) begin
                ack_done_reg <= 1'b1;
            end else if (!CYC_I) begin
                ack_done_reg <= 1'b0;
            end
        end
    end

    assign ACK_O      = ack_reg;
    assign ERR_O      = err_reg;
    assign RTY_O      = rty_reg;
    assign DAT_O      = dat_reg;
    assign xfer_cnt_o = xfer_cnt_reg;

endmodule

// File: tb/tb_wb_slave_resp.sv
// Directed bench for wb_slave_resp: single transfers, wait states, bursts,
// retries, errors, byte selects, cycle aborts and asynchronous reset.
module tb_wb_slave_resp;
    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_ACK  = 3'b001;
    localparam logic [2:0] R_ERR  = 3'b010;
    localparam logic [2:0] R_RTY  = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [2:0]  cti;
    logic [31:0] dat_o;
    logic        ack, err, rty;
    logic [3:0]  cfg_wait, cfg_rty;
    logic        cfg_err_en;
    logic [15:0] xfer_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] bw [4];
    logic [2:0]  resp;
    logic [31:0] rdat;
    int          lat;
    logic [2:0]  seen;

    always #5 clk = ~clk;

    wb_slave_resp #(.AW(32), .MEM_WORDS_LOG2(8)) dut (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
        .ADR_I(adr), .SEL_I(sel), .DAT_I(dat_i), .CTI_I(cti),
        .DAT_O(dat_o), .ACK_O(ack), .ERR_O(err), .RTY_O(rty),
        .cfg_wait_i(cfg_wait), .cfg_rty_i(cfg_rty), .cfg_err_en_i(cfg_err_en),
        .xfer_cnt_o(xfer_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single classic transfer; lat counts edges after t0 until the response shows.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [2:0] r,
                        output logic [31:0] rd, output int l);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d; cti = 3'b000;
        r = R_NONE; rd = 32'd0; l = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({rty, err, ack} != 3'b000) begin
                r = {rty, err, ack};
                rd = dat_o;
                l = i;
                break;
            end
        end
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("resp_one_cycle", {29'd0, rty, err, ack}, 32'd0);
        check("dat_zero_after", dat_o, 32'd0);
        step();
        $display("xfer we=%0d adr=%h sel=%b dat=%h -> resp=%b lat=%0d rdata=%h cnt=%0d",
                 w, a, s, d, r, l, rd, xfer_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bw[0] = 32'hA5A50001; bw[1] = 32'h5A5A0002;
        bw[2] = 32'hC3C30003; bw[3] = 32'h3C3C0004;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; sel = 4'd0;
        dat_i = 32'd0; cti = 3'b000; cfg_wait = 4'd0; cfg_rty = 4'd0; cfg_err_en = 1'b0;
        repeat (2) step();
        check("rst_resp", {29'd0, rty, err, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
        rst = 1'b0;
        step();

        // Zero-wait write then read back.
        xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, resp, rdat, lat);
        check("w0_resp", {29'd0, resp}, {29'd0, R_ACK});
        check("w0_lat", lat, 0);
        xfer(1'b0, 32'h10, 4'hF, 32'h0, resp, rdat, lat);
        check("r0_resp", {29'd0, resp}, {29'd0, R_ACK});
        check("r0_lat", lat, 0);
        check("r0_data", rdat, 32'hDEADBEEF);
        check("cnt_after_2", {16'd0, xfer_cnt}, 32'd2);

        // Three wait states.
        cfg_wait = 4'd3;
        xfer(1'b0, 32'h10, 4'hF, 32'h0, resp, rdat, lat);
        check("w3_resp", {29'd0, resp}, {29'd0, R_ACK});
        check("w3_lat", lat, 3);
        check("w3_data", rdat, 32'hDEADBEEF);
        cfg_wait = 4'd0;

        // Four-beat incrementing read burst over prewritten words.
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 32'(i * 4), 4'hF, bw[i], resp, rdat, lat);
        end
        check("pre_cnt", {16'd0, xfer_cnt}, 32'd7);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF; cti = 3'b010;
        step();
        check("burst_ack0", {31'd0, ack}, 32'd1);
        check("burst_dat0", dat_o, bw[0]);
        for (int b = 1; b < 4; b++) begin
            step();
            adr = 32'(b * 4);
            cti = (b == 3) ? 3'b111 : 3'b010;
            check("burst_ack", {31'd0, ack}, 32'd1);
            check("burst_dat", dat_o, bw[b]);
        end
        step();
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        check("burst_end_ack", {31'd0, ack}, 32'd0);
        check("burst_cnt", {16'd0, xfer_cnt}, 32'd11);
        step();
        $display("burst read adr=00..0c beats=4 cnt=%0d", xfer_cnt);

        // Retry budget of two loaded at reset release.
        rst = 1'b1; cfg_rty = 4'd2;
        step();
        check("rst2_cnt", {16'd0, xfer_cnt}, 32'd0);
        rst = 1'b0;
        step();
        cfg_rty = 4'd0;
        xfer(1'b0, 32'h10, 4'hF, 32'h0, resp, rdat, lat);
        check("rty1", {29'd0, resp}, {29'd0, R_RTY});
        xfer(1'b0, 32'h10, 4'hF, 32'h0, resp, rdat, lat);
        check("rty2", {29'd0, resp}, {29'd0, R_RTY});
        xfer(1'b0, 32'h10, 4'hF, 32'h0, resp, rdat, lat);
        check("rty3_ack", {29'd0, resp}, {29'd0, R_ACK});
        check("rty3_data", rdat, 32'hDEADBEEF);
        check("rty_cnt", {16'd0, xfer_cnt}, 32'd1);

        // Out-of-window write errors and must not alias onto word 0.
        cfg_err_en = 1'b1;
        xfer(1'b1, 32'h400, 4'hF, 32'h12345678, resp, rdat, lat);
        check("err_resp", {29'd0, resp}, {29'd0, R_ERR});
        xfer(1'b0, 32'h0, 4'hF, 32'h0, resp, rdat, lat);
        check("err_nowrite", rdat, bw[0]);
        cfg_err_en = 1'b0;
        xfer(1'b0, 32'h400, 4'hF, 32'h0, resp, rdat, lat);
        check("wrap_resp", {29'd0, resp}, {29'd0, R_ACK});
        check("wrap_data", rdat, bw[0]);

        // Single-byte lane write.
        xfer(1'b1, 32'h20, 4'hF, 32'h11223344, resp, rdat, lat);
        xfer(1'b1, 32'h20, 4'b0010, 32'h0000AB00, resp, rdat, lat);
        xfer(1'b0, 32'h20, 4'hF, 32'h0, resp, rdat, lat);
        check("sel_data", rdat, 32'h1122AB44);

        // CYC dropped during wait states: no response, no write.
        cfg_wait = 4'd3;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; dat_i = 32'hCAFEF00D;
        step();
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        seen = 3'b000;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | {rty, err, ack};
        end
        check("cyc_drop_resp", {29'd0, seen}, 32'd0);
        $display("cyc drop in wait adr=20 seen=%b", seen);
        cfg_wait = 4'd0;
        xfer(1'b0, 32'h20, 4'hF, 32'h0, resp, rdat, lat);
        check("cyc_drop_nowrite", rdat, 32'h1122AB44);

        // Asynchronous reset while ACK is high.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h20; sel = 4'hF;
        step();
        check("pre_rst_ack", {31'd0, ack}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_ack", {31'd0, ack}, 32'd0);
        check("async_rst_dat", dat_o, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        step();
        rst = 1'b0;
        step();
        $display("async reset during ack adr=20");

        // Reset during wait states aborts the pending write.
        cfg_wait = 4'd3;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; dat_i = 32'hCAFEF00D;
        step();
        step();
        rst = 1'b1;
        #1;
        check("rst_wait_resp", {29'd0, rty, err, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();
        rst = 1'b0;
        step();
        cfg_wait = 4'd0;
        xfer(1'b0, 32'h20, 4'hF, 32'h0, resp, rdat, lat);
        check("rst_wait_nowrite", rdat, 32'h1122AB44);
        check("rst_wait_cnt", {16'd0, xfer_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
